hdlc_rx_frame_ctrl: RTL and testbench
=====================================

// Module: hdlc_rx_frame_ctrl
// PURPOSE
//  Frame-level sequencer for the HDLC receive path. Consumes flag/abort/byte
//  strobes from the Rx deserializer and drives buffer writes, frame status and
//  CPU-facing ready/size. Sits between the Rx datapath and the Rx frame buffer.
//  Owns Rx_ValidFrame, Rx_AbortSignal, Rx_Overflow and Rx_WrBuff.
// PARAMETERS
//  MAX_BYTES  128  buffer depth in bytes; includes the 2 FCS bytes
//  MIN_FRAME  4    minimum bytes between flags for a legal frame (2 data + 2 FCS)
//  ADDR_W     7    buffer address width; must satisfy 2**ADDR_W >= MAX_BYTES
// PORTS
//  Clk             in   1       system clock, rising edge
//  Rst             in   1       async reset, active-low
//  Rx_Enable       in   1       receiver enable; low forces IDLE
//  Rx_FlagDetect   in   1       1-cycle pulse: flag 01111110 received
//  Rx_AbortDetect  in   1       1-cycle pulse: 7+ consecutive ones received
//  Rx_NewByte      in   1       1-cycle pulse: Rx_Data holds a complete byte
//  Rx_Data         in   8       deserialized byte, valid with Rx_NewByte
//  Rx_RdBuff       in   1       CPU read strobe, one byte per pulse
//  Rx_Drop         in   1       CPU pulse: discard stored frame
//  Rx_ValidFrame   out  1       high while a frame is being received
//  Rx_AbortSignal  out  1       1-cycle pulse, cycle after abort inside frame
//  Rx_Overflow     out  1       sticky: frame exceeded MAX_BYTES
//  Rx_WrBuff       out  1       buffer write strobe
//  Rx_WrAddr       out  ADDR_W  buffer write address
//  Rx_WrData       out  8       buffer write data (registered Rx_Data)
//  Rx_RdAddr       out  ADDR_W  buffer read address
//  Rx_EoF          out  1       1-cycle pulse: frame closed and stored
//  Rx_Ready        out  1       stored frame available to CPU
//  Rx_FrameSize    out  8       data bytes in stored frame (FCS excluded)
//  Rx_FrameError   out  1       1-cycle pulse: closing flag after <MIN_FRAME bytes
//  Rx_FCSerr       out  1       FCS mismatch on stored frame (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, byte count, read and write pointers 0.
//  FSM (state register), transitions on posedge Clk:
//   IDLE : Rx_FlagDetect -> FRAME; count<=0.
//   FRAME: Rx_ValidFrame=1 (registered; rises the cycle after the opening flag).
//    Rx_NewByte: if count<MAX_BYTES then Rx_WrBuff=1, Rx_WrAddr=count,
//     count++ (1-cycle latency, write cycle after the strobe);
//     else set Rx_Overflow, no write.
//    Rx_FlagDetect with count==0: stay FRAME (idle flag fill).
//    Rx_FlagDetect, 0<count<MIN_FRAME: Rx_FrameError pulse; stay FRAME, count<=0
//     (closing flag reopens the next frame).
//    Rx_FlagDetect, count>=MIN_FRAME: Rx_EoF pulse; Rx_FrameSize<=count-2; ->DONE.
//    Rx_AbortDetect: Rx_AbortSignal pulse next cycle; -> IDLE; frame discarded.
//   DONE : Rx_Ready=1; Rx_RdBuff increments Rx_RdAddr. Last read
//    (Rx_RdAddr==Rx_FrameSize-1) or Rx_Drop -> IDLE, Rx_Ready<=0, Rx_RdAddr<=0.
//    Line strobes ignored in DONE (no writes, no abort pulse).
//  Precedence in one cycle: Rx_Enable low > Rx_AbortDetect > Rx_FlagDetect >
//   Rx_NewByte. A Rx_NewByte coincident with a flag or abort is dropped.
//  Rx_Overflow clears on the next opening flag or on reset; frame still closes
//   with Rx_EoF and Rx_FrameSize=MAX_BYTES-2.
//  Rx_Enable low: synchronous return to IDLE; every output except Rx_Overflow
//   cleared next cycle.
//  Reset asserted mid-frame: immediate return to reset values, no Rx_EoF.
//  count and Rx_FrameSize are unsigned and never wrap; count saturates at MAX_BYTES.
// CONFIGURATION
//  HDLC_RX_FCS_CHECK_EN defined: CRC-16/X.25 (poly 0x1021, init 0xFFFF,
//   reflected) updated on every written byte; at Rx_EoF Rx_FCSerr<=1 if the
//   residue != 0xF0B8; cleared on leaving DONE.
//  Undefined: no CRC logic; Rx_FCSerr tied 0.
// TESTING
//  1 flag, bytes 0xA5,0x5A,FCS(2), flag -> 4 writes at addr 0..3, Rx_EoF, FrameSize=2
//  2 flag, 3 bytes, abort -> Rx_AbortSignal exactly 1 cycle after abort; IDLE; no EoF
//  3 flag, 130 bytes, flag -> 128 writes, Rx_Overflow=1, FrameSize=126
//  4 flag, 2 bytes, flag -> Rx_FrameError pulse; FRAME held; next 4 bytes+flag -> EoF
//  5 DONE, FrameSize=2: 2 Rx_RdBuff -> Rx_RdAddr 0,1 then Rx_Ready=0; repeat, Rx_Drop -> IDLE
//  6 FCS_EN: good frame -> Rx_FCSerr=0; one data bit flipped -> Rx_FCSerr=1

Source files
------------

// File: rtl/hdlc_rx_frame_ctrl.sv
// hdlc_rx_frame_ctrl
// Frame-level sequencer for the HDLC receive path. Takes flag/abort/byte
// strobes from the Rx deserializer, writes received bytes into the Rx frame
// buffer, and presents the finished frame (ready/size/read address) to the CPU.
//
// Optional build macro: HDLC_RX_FCS_CHECK_EN
//   defined   -> CRC-16/X.25 runs over every written byte; Rx_FCSerr flags a bad
//                residue at end of frame.
//   undefined -> no CRC logic, Rx_FCSerr tied low.
//
// Ports
//   Clk, Rst          clock (rising edge), async reset (active-low)
//   Rx_Enable         receiver enable; low returns to IDLE
//   Rx_FlagDetect     flag pulse from deserializer
//   Rx_AbortDetect    abort pulse from deserializer
//   Rx_NewByte/Rx_Data  byte strobe and byte
//   Rx_RdBuff/Rx_Drop CPU read strobe / discard stored frame
//   Rx_ValidFrame     frame in progress
//   Rx_AbortSignal    one-cycle abort indication
//   Rx_Overflow       sticky overflow flag
//   Rx_WrBuff/Rx_WrAddr/Rx_WrData  buffer write port
//   Rx_RdAddr         buffer read address
//   Rx_EoF            one-cycle end-of-frame pulse
//   Rx_Ready/Rx_FrameSize  stored frame available / data byte count
//   Rx_FrameError     one-cycle short-frame pulse
//   Rx_FCSerr         FCS mismatch on stored frame
//
// state | meaning
// IDLE  | waiting for an opening flag
// FRAME | receiving bytes between flags
// DONE  | frame stored, CPU reading or dropping it
module hdlc_rx_frame_ctrl #(
  parameter int MAX_BYTES = 128,
  parameter int MIN_FRAME = 4,
  parameter int ADDR_W    = 7
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx_Enable,
  input  logic              Rx_FlagDetect,
  input  logic              Rx_AbortDetect,
  input  logic              Rx_NewByte,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_RdBuff,
  input  logic              Rx_Drop,
  output logic              Rx_ValidFrame,
  output logic              Rx_AbortSignal,
  output logic              Rx_Overflow,
  output logic              Rx_WrBuff,
  output logic [ADDR_W-1:0] Rx_WrAddr,
  output logic [7:0]        Rx_WrData,
  output logic [ADDR_W-1:0] Rx_RdAddr,
  output logic              Rx_EoF,
  output logic              Rx_Ready,
  output logic [7:0]        Rx_FrameSize,
  output logic              Rx_FrameError,
  output logic              Rx_FCSerr
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {IDLE, FRAME, DONE} state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   count, countNext;
  logic               validFrameNext, abortNext, overflowNext, wrBuffNext;
  logic [ADDR_W-1:0]  wrAddrNext, rdAddrNext;
  logic [7:0]         wrDataNext, frameSizeNext;
  logic               eofNext, readyNext, frameErrorNext;
  logic [7:0]         rdAddrExt;

  assign rdAddrExt = 8'(Rx_RdAddr);

`ifdef HDLC_RX_FCS_CHECK_EN
  logic [15:0] crc, crcNext;
  logic        fcsErrNext;

  // Reflected CRC-16/X.25 byte update (poly 0x1021 reversed = 0x8408).
  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction
`else
  assign Rx_FCSerr = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state          <= IDLE;
      count          <= '0;
      Rx_ValidFrame  <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_WrBuff      <= 1'b0;
      Rx_WrAddr      <= '0;
      Rx_WrData      <= '0;
      Rx_RdAddr      <= '0;
      Rx_EoF         <= 1'b0;
      Rx_Ready       <= 1'b0;
      Rx_FrameSize   <= '0;
      Rx_FrameError  <= 1'b0;
`ifdef HDLC_RX_FCS_CHECK_EN
      crc            <= 16'hFFFF;
      Rx_FCSerr      <= 1'b0;
`endif
    end else begin
      state          <= stateNext;
      count          <= countNext;
      Rx_ValidFrame  <= validFrameNext;
      Rx_AbortSignal <= abortNext;
      Rx_Overflow    <= overflowNext;
      Rx_WrBuff      <= wrBuffNext;
      Rx_WrAddr      <= wrAddrNext;
      Rx_WrData      <= wrDataNext;
      Rx_RdAddr      <= rdAddrNext;
      Rx_EoF         <= eofNext;
      Rx_Ready       <= readyNext;
      Rx_FrameSize   <= frameSizeNext;
      Rx_FrameError  <= frameErrorNext;
`ifdef HDLC_RX_FCS_CHECK_EN
      crc            <= crcNext;
      Rx_FCSerr      <= fcsErrNext;
`endif
    end
  end

  always_comb begin
    stateNext      = state;
    countNext      = count;
    validFrameNext = 1'b0;
    abortNext      = 1'b0;
    overflowNext   = Rx_Overflow;
    wrBuffNext     = 1'b0;
    wrAddrNext     = Rx_WrAddr;
    wrDataNext     = Rx_WrData;
    rdAddrNext     = Rx_RdAddr;
    eofNext        = 1'b0;
    readyNext      = 1'b0;
    frameSizeNext  = Rx_FrameSize;
    frameErrorNext = 1'b0;
`ifdef HDLC_RX_FCS_CHECK_EN
    crcNext        = crc;
    fcsErrNext     = Rx_FCSerr;
`endif

    if (!Rx_Enable) begin
      // Overflow is the only output that survives a disable.
      stateNext     = IDLE;
      countNext     = '0;
      wrAddrNext    = '0;
      wrDataNext    = '0;
      rdAddrNext    = '0;
      frameSizeNext = '0;
`ifdef HDLC_RX_FCS_CHECK_EN
      fcsErrNext    = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Rx_FlagDetect) begin
            stateNext      = FRAME;
            countNext      = '0;
            overflowNext   = 1'b0;
            validFrameNext = 1'b1;
`ifdef HDLC_RX_FCS_CHECK_EN
            crcNext        = 16'hFFFF;
`endif
          end
        end
        FRAME: begin
          validFrameNext = 1'b1;
          if (Rx_AbortDetect) begin
            stateNext      = IDLE;
            abortNext      = 1'b1;
            validFrameNext = 1'b0;
            countNext      = '0;
          end else if (Rx_FlagDetect) begin
            if (count == '0) begin
              // idle flag fill between frames
            end else if (count < CNT_W'(MIN_FRAME)) begin
              // Short frame: its closing flag doubles as the next opening flag.
              frameErrorNext = 1'b1;
              countNext      = '0;
`ifdef HDLC_RX_FCS_CHECK_EN
              crcNext        = 16'hFFFF;
`endif
            end else begin
              stateNext      = DONE;
              eofNext        = 1'b1;
              readyNext      = 1'b1;
              validFrameNext = 1'b0;
              frameSizeNext  = 8'(count - CNT_W'(2));
              countNext      = '0;
`ifdef HDLC_RX_FCS_CHECK_EN
              fcsErrNext     = (crc != 16'hF0B8);
`endif
            end
          end else if (Rx_NewByte) begin
            if (count < CNT_W'(MAX_BYTES)) begin
              wrBuffNext = 1'b1;
              wrAddrNext = count[ADDR_W-1:0];
              wrDataNext = Rx_Data;
              countNext  = count + CNT_W'(1);
`ifdef HDLC_RX_FCS_CHECK_EN
              crcNext    = crcByte(crc, Rx_Data);
`endif
            end else begin
              overflowNext = 1'b1;
            end
          end
        end
        DONE: begin
          readyNext = 1'b1;
          if (Rx_Drop || (Rx_RdBuff && (rdAddrExt == Rx_FrameSize - 8'd1))) begin
            stateNext  = IDLE;
            readyNext  = 1'b0;
            rdAddrNext = '0;
`ifdef HDLC_RX_FCS_CHECK_EN
            fcsErrNext = 1'b0;
`endif
          end else if (Rx_RdBuff) begin
            rdAddrNext = Rx_RdAddr + ADDR_W'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Directed testbench for hdlc_rx_frame_ctrl. Inputs are driven on the falling
// edge; after each strobe task returns (at the next falling edge) the outputs
// hold the registered response to that strobe.
module tb_hdlc_rx_frame_ctrl;
  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Rx_Enable = 1'b0, Rx_FlagDetect = 1'b0, Rx_AbortDetect = 1'b0;
  logic       Rx_NewByte = 1'b0, Rx_RdBuff = 1'b0, Rx_Drop = 1'b0;
  logic [7:0] Rx_Data = 8'h00;
  logic       Rx_ValidFrame, Rx_AbortSignal, Rx_Overflow, Rx_WrBuff;
  logic [6:0] Rx_WrAddr, Rx_RdAddr;
  logic [7:0] Rx_WrData, Rx_FrameSize;
  logic       Rx_EoF, Rx_Ready, Rx_FrameError, Rx_FCSerr;

  int errors = 0;
  int checks = 0;
  int wrCount = 0, addrErr = 0, eofCount = 0, abortCount = 0;
  logic [7:0] wrLog [0:255];

  hdlc_rx_frame_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Rx_Enable(Rx_Enable), .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data),
    .Rx_RdBuff(Rx_RdBuff), .Rx_Drop(Rx_Drop), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_Overflow(Rx_Overflow), .Rx_WrBuff(Rx_WrBuff),
    .Rx_WrAddr(Rx_WrAddr), .Rx_WrData(Rx_WrData), .Rx_RdAddr(Rx_RdAddr),
    .Rx_EoF(Rx_EoF), .Rx_Ready(Rx_Ready), .Rx_FrameSize(Rx_FrameSize),
    .Rx_FrameError(Rx_FrameError), .Rx_FCSerr(Rx_FCSerr)
  );

  always #5 Clk = ~Clk;

  // Write/event monitor: writes must be sequential from address 0 in a frame.
  always @(posedge Clk) begin
    #2;
    if (Rx_WrBuff) begin
      if (Rx_WrAddr !== wrCount[6:0]) addrErr++;
      if (wrCount < 256) wrLog[wrCount] = Rx_WrData;
      wrCount++;
    end
    if (Rx_EoF) eofCount++;
    if (Rx_AbortSignal) abortCount++;
  end

  // Reference CRC-16/X.25 (reflected, poly 0x8408) used to build FCS bytes.
  function automatic logic [15:0] refCrc(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic clearMon();
    wrCount = 0; addrErr = 0; eofCount = 0; abortCount = 0;
  endtask

  task automatic pulseFlag();
    Rx_FlagDetect = 1'b1; @(negedge Clk); Rx_FlagDetect = 1'b0;
  endtask

  task automatic pulseAbort();
    Rx_AbortDetect = 1'b1; @(negedge Clk); Rx_AbortDetect = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    Rx_Data = b; Rx_NewByte = 1'b1; @(negedge Clk); Rx_NewByte = 1'b0;
  endtask

  task automatic pulseRd();
    Rx_RdBuff = 1'b1; @(negedge Clk); Rx_RdBuff = 1'b0;
  endtask

  task automatic pulseDrop();
    Rx_Drop = 1'b1; @(negedge Clk); Rx_Drop = 1'b0;
  endtask

  // Two data bytes plus FCS; flip inverts bit 0 of the first data byte on the
  // line while the FCS is still computed over the original byte.
  task automatic sendFcsFrame(input logic [7:0] d0, input logic [7:0] d1, input logic flip);
    logic [15:0] c;
    logic [15:0] fcs;
    c = refCrc(16'hFFFF, d0);
    c = refCrc(c, d1);
    fcs = ~c;
    pulseFlag();
    sendByte(flip ? (d0 ^ 8'h01) : d0); @(negedge Clk);
    sendByte(d1); @(negedge Clk);
    sendByte(fcs[7:0]); @(negedge Clk);
    sendByte(fcs[15:8]); @(negedge Clk);
    pulseFlag();
  endtask

  task automatic test_reset();
    @(negedge Clk);
    checks++;
    if ({Rx_ValidFrame, Rx_AbortSignal, Rx_Overflow, Rx_WrBuff, Rx_EoF, Rx_Ready,
         Rx_FrameError, Rx_FCSerr} !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b want 00000000", {Rx_ValidFrame, Rx_AbortSignal,
        Rx_Overflow, Rx_WrBuff, Rx_EoF, Rx_Ready, Rx_FrameError, Rx_FCSerr});
    end
    checks++;
    if ({Rx_WrAddr, Rx_RdAddr, Rx_WrData, Rx_FrameSize} !== 30'h0) begin
      errors++; $display("FAIL reset_buses: wa=%0d ra=%0d wd=%0h fs=%0d want all 0",
        Rx_WrAddr, Rx_RdAddr, Rx_WrData, Rx_FrameSize);
    end
    Rst = 1'b1; Rx_Enable = 1'b1;
    @(negedge Clk);
    clearMon();
  endtask

  task automatic test_good_frame();
    logic [7:0] bytes [0:3];
    bytes[0] = 8'hA5; bytes[1] = 8'h5A;
    bytes[2] = ~refCrc(refCrc(16'hFFFF, 8'hA5), 8'h5A) & 16'h00FF;
    bytes[3] = (~refCrc(refCrc(16'hFFFF, 8'hA5), 8'h5A)) >> 8;
    clearMon();
    pulseFlag();
    checks++;
    if (Rx_ValidFrame !== 1'b1) begin errors++; $display("FAIL open_valid: got %b want 1", Rx_ValidFrame); end
    for (int i = 0; i < 4; i++) begin
      sendByte(bytes[i]);
      checks++;
      if (Rx_WrBuff !== 1'b1 || Rx_WrAddr !== 7'(i) || Rx_WrData !== bytes[i]) begin
        errors++; $display("FAIL good_write%0d: wr=%b addr=%0d data=%0h want 1 %0d %0h",
          i, Rx_WrBuff, Rx_WrAddr, Rx_WrData, i, bytes[i]);
      end
      @(negedge Clk);
    end
    pulseFlag();
    checks++;
    if (Rx_EoF !== 1'b1 || Rx_Ready !== 1'b1 || Rx_FrameSize !== 8'd2 || Rx_ValidFrame !== 1'b0) begin
      errors++; $display("FAIL good_eof: eof=%b rdy=%b size=%0d valid=%b want 1 1 2 0",
        Rx_EoF, Rx_Ready, Rx_FrameSize, Rx_ValidFrame);
    end
    checks++;
    if (Rx_FCSerr !== 1'b0) begin errors++; $display("FAIL good_fcs: got %b want 0", Rx_FCSerr); end
    @(negedge Clk);
    checks++;
    if (Rx_EoF !== 1'b0 || Rx_Ready !== 1'b1 || wrCount != 4 || addrErr != 0) begin
      errors++; $display("FAIL good_after: eof=%b rdy=%b writes=%0d addrErr=%0d want 0 1 4 0",
        Rx_EoF, Rx_Ready, wrCount, addrErr);
    end
    pulseDrop();
    checks++;
    if (Rx_Ready !== 1'b0) begin errors++; $display("FAIL good_drop: ready=%b want 0", Rx_Ready); end
  endtask

  task automatic test_abort();
    clearMon();
    pulseFlag();
    for (int i = 0; i < 3; i++) begin sendByte(8'h10 + 8'(i)); @(negedge Clk); end
    pulseAbort();
    checks++;
    if (Rx_AbortSignal !== 1'b1 || Rx_ValidFrame !== 1'b0) begin
      errors++; $display("FAIL abort_pulse: abort=%b valid=%b want 1 0", Rx_AbortSignal, Rx_ValidFrame);
    end
    @(negedge Clk);
    checks++;
    if (Rx_AbortSignal !== 1'b0 || abortCount != 1) begin
      errors++; $display("FAIL abort_width: abort=%b pulses=%0d want 0 1", Rx_AbortSignal, abortCount);
    end
    sendByte(8'h77);
    checks++;
    if (Rx_WrBuff !== 1'b0 || eofCount != 0 || Rx_Ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle: wr=%b eofs=%0d rdy=%b want 0 0 0", Rx_WrBuff, eofCount, Rx_Ready);
    end
    pulseAbort();
    @(negedge Clk);
    checks++;
    if (abortCount != 1) begin errors++; $display("FAIL abort_in_idle: pulses=%0d want 1", abortCount); end
  endtask

  task automatic test_overflow();
    clearMon();
    pulseFlag();
    for (int i = 0; i < 130; i++) sendByte(8'(i * 3));
    @(negedge Clk);
    checks++;
    if (wrCount != 128 || addrErr != 0 || Rx_Overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_writes: writes=%0d addrErr=%0d ovf=%b want 128 0 1", wrCount, addrErr, Rx_Overflow);
    end
    checks++;
    if (wrLog[127] !== 8'(127 * 3)) begin errors++; $display("FAIL ovf_lastdata: got %0h want %0h", wrLog[127], 8'(127 * 3)); end
    pulseFlag();
    checks++;
    if (Rx_EoF !== 1'b1 || Rx_FrameSize !== 8'd126 || Rx_Overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_eof: eof=%b size=%0d ovf=%b want 1 126 1", Rx_EoF, Rx_FrameSize, Rx_Overflow);
    end
    Rx_Enable = 1'b0;
    @(negedge Clk);
    checks++;
    if (Rx_Ready !== 1'b0 || Rx_FrameSize !== 8'd0 || Rx_Overflow !== 1'b1) begin
      errors++; $display("FAIL disable_keep_ovf: rdy=%b size=%0d ovf=%b want 0 0 1", Rx_Ready, Rx_FrameSize, Rx_Overflow);
    end
    Rx_Enable = 1'b1;
    pulseFlag();
    checks++;
    if (Rx_Overflow !== 1'b0 || Rx_ValidFrame !== 1'b1) begin
      errors++; $display("FAIL ovf_clear: ovf=%b valid=%b want 0 1", Rx_Overflow, Rx_ValidFrame);
    end
    pulseAbort();
    @(negedge Clk);
  endtask

  task automatic test_frame_error();
    clearMon();
    pulseFlag();
    sendByte(8'h01); @(negedge Clk);
    sendByte(8'h02); @(negedge Clk);
    pulseFlag();
    checks++;
    if (Rx_FrameError !== 1'b1 || Rx_ValidFrame !== 1'b1 || Rx_EoF !== 1'b0) begin
      errors++; $display("FAIL ferr_pulse: ferr=%b valid=%b eof=%b want 1 1 0", Rx_FrameError, Rx_ValidFrame, Rx_EoF);
    end
    @(negedge Clk);
    checks++;
    if (Rx_FrameError !== 1'b0) begin errors++; $display("FAIL ferr_width: got %b want 0", Rx_FrameError); end
    wrCount = 0; addrErr = 0;
    for (int i = 0; i < 4; i++) begin sendByte(8'hC0 + 8'(i)); @(negedge Clk); end
    pulseFlag();
    checks++;
    if (Rx_EoF !== 1'b1 || Rx_FrameSize !== 8'd2 || addrErr != 0 || wrCount != 4) begin
      errors++; $display("FAIL ferr_reopen: eof=%b size=%0d addrErr=%0d writes=%0d want 1 2 0 4",
        Rx_EoF, Rx_FrameSize, addrErr, wrCount);
    end
  endtask

  // Entered in DONE with FrameSize 2 from test_frame_error.
  task automatic test_read();
    checks++;
    if (Rx_Ready !== 1'b1 || Rx_RdAddr !== 7'd0) begin
      errors++; $display("FAIL rd_start: rdy=%b ra=%0d want 1 0", Rx_Ready, Rx_RdAddr);
    end
    pulseRd();
    checks++;
    if (Rx_RdAddr !== 7'd1 || Rx_Ready !== 1'b1) begin
      errors++; $display("FAIL rd_first: ra=%0d rdy=%b want 1 1", Rx_RdAddr, Rx_Ready);
    end
    pulseRd();
    checks++;
    if (Rx_RdAddr !== 7'd0 || Rx_Ready !== 1'b0) begin
      errors++; $display("FAIL rd_last: ra=%0d rdy=%b want 0 0", Rx_RdAddr, Rx_Ready);
    end
    pulseFlag();
    for (int i = 0; i < 4; i++) begin sendByte(8'h33); @(negedge Clk); end
    pulseFlag();
    clearMon();
    sendByte(8'h44);
    pulseAbort();
    checks++;
    if (Rx_Ready !== 1'b1 || wrCount != 0 || Rx_AbortSignal !== 1'b0) begin
      errors++; $display("FAIL done_ignore: rdy=%b writes=%0d abort=%b want 1 0 0", Rx_Ready, wrCount, Rx_AbortSignal);
    end
    pulseDrop();
    checks++;
    if (Rx_Ready !== 1'b0 || Rx_RdAddr !== 7'd0) begin
      errors++; $display("FAIL rd_drop: rdy=%b ra=%0d want 0 0", Rx_Ready, Rx_RdAddr);
    end
    sendByte(8'h55);
    checks++;
    if (Rx_WrBuff !== 1'b0 || Rx_ValidFrame !== 1'b0) begin
      errors++; $display("FAIL drop_idle: wr=%b valid=%b want 0 0", Rx_WrBuff, Rx_ValidFrame);
    end
  endtask

  task automatic test_precedence();
    clearMon();
    pulseFlag();
    Rx_FlagDetect = 1'b1; Rx_NewByte = 1'b1; Rx_Data = 8'h99;
    @(negedge Clk);
    Rx_FlagDetect = 1'b0; Rx_NewByte = 1'b0;
    checks++;
    if (Rx_WrBuff !== 1'b0 || Rx_ValidFrame !== 1'b1) begin
      errors++; $display("FAIL flag_beats_byte: wr=%b valid=%b want 0 1", Rx_WrBuff, Rx_ValidFrame);
    end
    for (int i = 0; i < 4; i++) begin sendByte(8'h20); @(negedge Clk); end
    Rx_FlagDetect = 1'b1; Rx_AbortDetect = 1'b1;
    @(negedge Clk);
    Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0;
    checks++;
    if (Rx_AbortSignal !== 1'b1 || Rx_EoF !== 1'b0 || Rx_Ready !== 1'b0) begin
      errors++; $display("FAIL abort_beats_flag: abort=%b eof=%b rdy=%b want 1 0 0", Rx_AbortSignal, Rx_EoF, Rx_Ready);
    end
    pulseFlag();
    sendByte(8'h66);
    Rx_Enable = 1'b0; Rx_AbortDetect = 1'b1;
    @(negedge Clk);
    Rx_AbortDetect = 1'b0;
    checks++;
    if (Rx_ValidFrame !== 1'b0 || Rx_AbortSignal !== 1'b0 || Rx_WrAddr !== 7'd0 || Rx_WrData !== 8'h00) begin
      errors++; $display("FAIL disable_clear: valid=%b abort=%b wa=%0d wd=%0h want 0 0 0 0",
        Rx_ValidFrame, Rx_AbortSignal, Rx_WrAddr, Rx_WrData);
    end
    pulseFlag();
    checks++;
    if (Rx_ValidFrame !== 1'b0) begin errors++; $display("FAIL disable_flag: valid=%b want 0", Rx_ValidFrame); end
    Rx_Enable = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_frame();
    clearMon();
    pulseFlag();
    sendByte(8'hAB); @(negedge Clk);
    sendByte(8'hCD);
    #2 Rst = 1'b0;
    #1;
    checks++;
    if (Rx_ValidFrame !== 1'b0 || Rx_WrAddr !== 7'd0 || Rx_WrBuff !== 1'b0) begin
      errors++; $display("FAIL async_reset: valid=%b wa=%0d wr=%b want 0 0 0", Rx_ValidFrame, Rx_WrAddr, Rx_WrBuff);
    end
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    sendByte(8'hEE);
    checks++;
    if (Rx_WrBuff !== 1'b0 || eofCount != 0) begin
      errors++; $display("FAIL reset_idle: wr=%b eofs=%0d want 0 0", Rx_WrBuff, eofCount);
    end
  endtask

  task automatic test_fcs();
    sendFcsFrame(8'h12, 8'h34, 1'b0);
    checks++;
    if (Rx_EoF !== 1'b1 || Rx_FCSerr !== 1'b0) begin
      errors++; $display("FAIL fcs_good: eof=%b fcserr=%b want 1 0", Rx_EoF, Rx_FCSerr);
    end
    pulseDrop();
    sendFcsFrame(8'h12, 8'h34, 1'b1);
`ifdef HDLC_RX_FCS_CHECK_EN
    checks++;
    if (Rx_EoF !== 1'b1 || Rx_FCSerr !== 1'b1) begin
      errors++; $display("FAIL fcs_bad: eof=%b fcserr=%b want 1 1", Rx_EoF, Rx_FCSerr);
    end
    pulseDrop();
    checks++;
    if (Rx_FCSerr !== 1'b0) begin errors++; $display("FAIL fcs_clear: fcserr=%b want 0", Rx_FCSerr); end
`else
    checks++;
    if (Rx_EoF !== 1'b1 || Rx_FCSerr !== 1'b0) begin
      errors++; $display("FAIL fcs_tied: eof=%b fcserr=%b want 1 0", Rx_EoF, Rx_FCSerr);
    end
    pulseDrop();
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_abort();
    test_overflow();
    test_frame_error();
    test_read();
    test_precedence();
    test_reset_mid_frame();
    test_fcs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
